shot_scheduler: RTL and testbench

- Schedules the player's cannon shots in Doodle Jump: edge-detects the fire key, enforces a cooldown, allocates shots to a fixed pool of slots, advances each live shot upward once per frame, and retires shots that reach the top of the screen.
- Sits between the keyboard keycode and game-state FSM outputs and the sprite drawing logic.
- Takes the character position as the spawn point.
- Replaces single-cannon handling with a multi-slot, arbitrated resource.

---
 rtl/shot_scheduler.sv | 127 ++++++++++++
 tb/tb_shot_scheduler.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/shot_scheduler.sv
// Cannon shot scheduler: fire-key edge detect, cooldown, lowest-free slot
// allocation, per-frame upward advance and top-of-screen retirement.
module shot_scheduler #(
  parameter int         NUM_SLOTS  = 4,
  parameter int         SHOT_SPEED = 7,
  parameter int         COOLDOWN   = 8,
  parameter logic [7:0] FIRE_KEY   = 8'd44,
  parameter int         Y_MIN      = 0
) (
  input  logic                      frame_clk,
  input  logic                      Reset,
  input  logic [7:0]                keycode,
  input  logic [2:0]                game_state,
  input  logic [9:0]                spawn_x,
  input  logic [9:0]                spawn_y,
  output logic [10*NUM_SLOTS-1:0]   shot_x,
  output logic [10*NUM_SLOTS-1:0]   shot_y,
  output logic [NUM_SLOTS-1:0]      shot_valid,
  output logic                      fire_ack,
  output logic                      pool_full,
  output logic [7:0]                drop_cnt
);

  localparam logic [2:0]  GS_PLAY   = 3'b001;
  localparam logic [2:0]  GS_PAUSED = 3'b010;
  localparam logic [10:0] RETIRE_Y  = 11'(Y_MIN + SHOT_SPEED);
  localparam logic [9:0]  STEP      = 10'(SHOT_SPEED);
  localparam logic [7:0]  CD_LOAD   = 8'(COOLDOWN);

  logic [7:0]             prev_key;
  logic [7:0]             cooldown;
  logic [7:0]             nx_cd;
  logic [7:0]             nx_drop;
  logic [10*NUM_SLOTS-1:0] nx_x;
  logic [10*NUM_SLOTS-1:0] nx_y;
  logic [NUM_SLOTS-1:0]   nx_v;
  logic [NUM_SLOTS-1:0]   alloc;
  logic                   nx_ack;
  logic                   press;
  logic                   free_found;

  assign press = (keycode == FIRE_KEY) && (prev_key != FIRE_KEY);

  // Lowest free slot taken from frame-start valid bits, so a slot retiring
  // this frame is not handed out until the next one.
  always_comb begin
    alloc      = '0;
    free_found = 1'b0;
    for (int unsigned i = 0; i < NUM_SLOTS; i++) begin
      if (!shot_valid[i] && !free_found) begin
        alloc[i]   = 1'b1;
        free_found = 1'b1;
      end
    end
  end

  always_comb begin
    nx_x    = shot_x;
    nx_y    = shot_y;
    nx_v    = shot_valid;
    nx_cd   = cooldown;
    nx_drop = drop_cnt;
    nx_ack  = 1'b0;
    case (game_state)
      GS_PLAY: begin
        for (int unsigned i = 0; i < NUM_SLOTS; i++) begin
          if (shot_valid[i]) begin
            if ({1'b0, shot_y[10*i +: 10]} < RETIRE_Y) begin
              nx_v[i] = 1'b0;
            end else begin
              nx_y[10*i +: 10] = shot_y[10*i +: 10] - STEP;
            end
          end
        end
        if (cooldown != '0) begin
          nx_cd = cooldown - 8'd1;
        end
        if (press && (cooldown == '0)) begin
          if (free_found) begin
            for (int unsigned i = 0; i < NUM_SLOTS; i++) begin
              if (alloc[i]) begin
                nx_v[i]          = 1'b1;
                nx_x[10*i +: 10] = spawn_x;
                nx_y[10*i +: 10] = spawn_y;
              end
            end
            nx_ack = 1'b1;
            nx_cd  = CD_LOAD;
          end else if (drop_cnt != '1) begin
            nx_drop = drop_cnt + 8'd1;
          end
        end
      end
      GS_PAUSED: begin
      end
      default: begin
        nx_x  = '0;
        nx_y  = '0;
        nx_v  = '0;
        nx_cd = '0;
      end
    endcase
  end

  always_ff @(posedge frame_clk or posedge Reset) begin
    if (Reset) begin
      shot_x     <= '0;
      shot_y     <= '0;
      shot_valid <= '0;
      fire_ack   <= 1'b0;
      pool_full  <= 1'b0;
      drop_cnt   <= '0;
      cooldown   <= '0;
      prev_key   <= '0;
    end else begin
      shot_x     <= nx_x;
      shot_y     <= nx_y;
      shot_valid <= nx_v;
      fire_ack   <= nx_ack;
      pool_full  <= &nx_v;
      drop_cnt   <= nx_drop;
      cooldown   <= nx_cd;
      prev_key   <= keycode;
    end
  end

endmodule

// File: tb/tb_shot_scheduler.sv
// Scoreboarded bench for shot_scheduler: expected allocations are queued by
// the stimulus and checked by a monitor whenever fire_ack is seen.
module tb_shot_scheduler;

  logic        frame_clk = 1'b0;
  logic        Reset;
  logic [7:0]  keycode;
  logic [2:0]  game_state;
  logic [9:0]  spawn_x;
  logic [9:0]  spawn_y;
  logic [39:0] shot_x;
  logic [39:0] shot_y;
  logic [3:0]  shot_valid;
  logic        fire_ack;
  logic        pool_full;
  logic [7:0]  drop_cnt;

  logic [7:0]  key2;
  logic [2:0]  gs2;
  logic [39:0] x2;
  logic [39:0] y2;
  logic [3:0]  v2;
  logic        ack2;
  logic        full2;
  logic [7:0]  drop2;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int slot;
    int x;
    int y;
  } exp_t;
  exp_t exp_q[$];

  shot_scheduler dut (
    .frame_clk(frame_clk), .Reset(Reset), .keycode(keycode),
    .game_state(game_state), .spawn_x(spawn_x), .spawn_y(spawn_y),
    .shot_x(shot_x), .shot_y(shot_y), .shot_valid(shot_valid),
    .fire_ack(fire_ack), .pool_full(pool_full), .drop_cnt(drop_cnt)
  );

  // Non-moving shots with no cooldown keep the pool full for drop saturation.
  shot_scheduler #(.SHOT_SPEED(0), .COOLDOWN(0)) dut2 (
    .frame_clk(frame_clk), .Reset(Reset), .keycode(key2),
    .game_state(gs2), .spawn_x(spawn_x), .spawn_y(spawn_y),
    .shot_x(x2), .shot_y(y2), .shot_valid(v2),
    .fire_ack(ack2), .pool_full(full2), .drop_cnt(drop2)
  );

  always #5 frame_clk = ~frame_clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge frame_clk);
      #1;
    end
  endtask

  task automatic expect_fire(input int slot, input int x, input int y);
    exp_t e;
    e.slot = slot;
    e.x    = x;
    e.y    = y;
    exp_q.push_back(e);
  endtask

  function automatic int sy(input int s);
    return int'(shot_y[10*s +: 10]);
  endfunction

  function automatic int sx(input int s);
    return int'(shot_x[10*s +: 10]);
  endfunction

  task automatic fire_once(input int slot, input int x, input int y);
    keycode = 8'd44;
    expect_fire(slot, x, y);
    step(1);
    keycode = 8'd0;
    step(9);
  endtask

  always @(posedge frame_clk) begin
    #2;
    if (fire_ack === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_ack: got fire_ack=1 valid=%b expected no allocation", shot_valid);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        if (shot_valid[e.slot] !== 1'b1 || sx(e.slot) != e.x || sy(e.slot) != e.y) begin
          errors++;
          $display("FAIL alloc_slot%0d: got valid=%b x=%0d y=%0d expected valid=1 x=%0d y=%0d",
                   e.slot, shot_valid[e.slot], sx(e.slot), sy(e.slot), e.x, e.y);
        end
      end
    end
  end

  initial begin
    Reset = 1'b1;
    keycode = 8'd0; game_state = 3'b000; spawn_x = 10'd0; spawn_y = 10'd0;
    key2 = 8'd0; gs2 = 3'b000;
    #12;
    chk("rst_valid", int'(shot_valid), 0);
    chk("rst_ack", int'(fire_ack), 0);
    chk("rst_full", int'(pool_full), 0);
    chk("rst_drop", int'(drop_cnt), 0);
    chk("rst_xy", int'(shot_x | shot_y), 0);
    Reset = 1'b0;

    // Single shot: spawn, advance by 7 per frame, retire below y=7
    game_state = 3'b001; spawn_x = 10'd320; spawn_y = 10'd240;
    step(1);
    keycode = 8'd44;
    expect_fire(0, 320, 240);
    step(1);
    chk("first_valid", int'(shot_valid), 1);
    keycode = 8'd0;
    step(1);
    chk("ack_one_frame", int'(fire_ack), 0);
    chk("y_233", sy(0), 233);
    step(1);
    chk("y_226", sy(0), 226);
    step(32);
    chk("y_2", sy(0), 2);
    chk("y_2_valid", int'(shot_valid), 1);
    step(1);
    chk("retired", int'(shot_valid), 0);

    // Held key fires once; cooldown blocks early re-presses
    keycode = 8'd44;
    expect_fire(0, 320, 240);
    step(20);
    chk("hold_one_shot", int'(shot_valid), 1);
    chk("hold_y", sy(0), 107);
    keycode = 8'd0;
    step(1);
    keycode = 8'd44;
    expect_fire(1, 320, 240);
    step(1);
    keycode = 8'd0;  step(2);
    keycode = 8'd44; step(1);
    keycode = 8'd0;  step(4);
    keycode = 8'd44; step(1);
    chk("cd_last_frame", int'(shot_valid), 3);
    keycode = 8'd0;  step(1);
    keycode = 8'd44;
    expect_fire(2, 320, 240);
    step(1);
    keycode = 8'd0;
    chk("cd_expired", int'(shot_valid), 7);
    chk("cd_no_drop", int'(drop_cnt), 0);
    game_state = 3'b000;
    step(1);
    chk("idle_clear", int'(shot_valid), 0);
    chk("idle_xy", int'(shot_x | shot_y), 0);

    // Fill the pool, drop, then drop during a same-frame retire
    game_state = 3'b001; spawn_x = 10'd200; spawn_y = 10'd290;
    fire_once(0, 200, 290);
    fire_once(1, 200, 290);
    fire_once(2, 200, 290);
    fire_once(3, 200, 290);
    chk("full_valid", int'(shot_valid), 15);
    chk("full_flag", int'(pool_full), 1);
    keycode = 8'd44; step(1);
    chk("drop1_cnt", int'(drop_cnt), 1);
    chk("drop1_ack", int'(fire_ack), 0);
    chk("drop1_full", int'(pool_full), 1);
    keycode = 8'd0;  step(1);
    chk("slot0_y3", sy(0), 3);
    keycode = 8'd44; step(1);
    chk("drop2_cnt", int'(drop_cnt), 2);
    chk("retire_valid", int'(shot_valid), 14);
    chk("retire_full", int'(pool_full), 0);
    keycode = 8'd0;  step(1);
    spawn_x = 10'd100; spawn_y = 10'd200;
    keycode = 8'd44;
    expect_fire(0, 100, 200);
    step(1);
    keycode = 8'd0;
    chk("realloc_valid", int'(shot_valid), 15);
    game_state = 3'b000;
    step(1);
    chk("idle_drop_hold", int'(drop_cnt), 2);

    // Pause freezes shots and cooldown; held key across unpause is no press
    game_state = 3'b001; spawn_x = 10'd50; spawn_y = 10'd500;
    fire_once(0, 50, 500);
    keycode = 8'd44;
    expect_fire(1, 50, 500);
    step(1);
    game_state = 3'b010;
    step(10);
    chk("pause_y0", sy(0), 430);
    chk("pause_y1", sy(1), 500);
    chk("pause_valid", int'(shot_valid), 3);
    game_state = 3'b001;
    step(1);
    chk("unpause_y0", sy(0), 423);
    chk("unpause_y1", sy(1), 493);
    keycode = 8'd0;  step(1);
    keycode = 8'd44; step(1);
    keycode = 8'd0;
    chk("pause_cd_valid", int'(shot_valid), 3);
    chk("pause_cd_drop", int'(drop_cnt), 2);
    game_state = 3'b000;
    step(1);
    chk("idle_after_pause", int'(shot_valid), 0);
    chk("idle_full", int'(pool_full), 0);

    // Asynchronous reset with a live shot
    game_state = 3'b001; spawn_x = 10'd10; spawn_y = 10'd600;
    keycode = 8'd44;
    expect_fire(0, 10, 600);
    step(1);
    keycode = 8'd0;
    #2;
    Reset = 1'b1;
    #1;
    chk("async_valid", int'(shot_valid), 0);
    chk("async_ack", int'(fire_ack), 0);
    chk("async_drop", int'(drop_cnt), 0);
    chk("async_xy", int'(shot_x | shot_y), 0);
    #2;
    Reset = 1'b0;
    game_state = 3'b000;

    // Drop counter saturation on the non-moving instance
    gs2 = 3'b001;
    repeat (4) begin
      key2 = 8'd44; step(1);
      key2 = 8'd0;  step(1);
    end
    chk("sat_full", int'(full2), 1);
    chk("sat_static_y", int'(y2[9:0]), 600);
    repeat (255) begin
      key2 = 8'd44; step(1);
      key2 = 8'd0;  step(1);
    end
    chk("sat_255", int'(drop2), 255);
    repeat (5) begin
      key2 = 8'd44; step(1);
      key2 = 8'd0;  step(1);
    end
    key2 = 8'd44; step(1);
    chk("sat_ack", int'(ack2), 0);
    chk("sat_hold", int'(drop2), 255);
    chk("sat_valid", int'(v2), 15);
    key2 = 8'd0;
    step(2);

    chk("queue_drained", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
